// File: rtl/d5m_pkg.sv
// Shared types and defaults for the D5M capture sequencer.
package d5m_pkg;

    localparam int unsigned D5M_COLS  = 2592;
    localparam int unsigned D5M_LINES = 1944;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_IDLE = 2'd1,
        WAIT_SOF  = 2'd2,
        STREAM    = 2'd3
    } seq_state_e;

    // Counter width able to hold total-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned total);
        return (total > 1) ? $clog2(total) : 1;
    endfunction

endpackage

// File: rtl/d5m_pixel_counter.sv
// Pixel position counter within a frame, with first/last pixel decode.
module d5m_pixel_counter
    import d5m_pkg::*;
#(
    parameter int unsigned COLS  = D5M_COLS,
    parameter int unsigned LINES = D5M_LINES,
    parameter int unsigned CNT_W = cnt_width(COLS * LINES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             advance,
    output logic [CNT_W-1:0] count,
    output logic             first_c,
    output logic             last_c
);

    localparam int unsigned TOTAL = COLS * LINES;

    assign first_c = (count == '0);
    assign last_c  = (count == CNT_W'(TOTAL - 1));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (advance) begin
            count <= last_c ? '0 : count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/d5m_capture_sequencer.sv
// Frame capture sequencer: arms on command, streams whole frames as packets.
// Define D5M_SEQ_TEST_PATTERN_EN to replace pixel data with the pixel counter.
module d5m_capture_sequencer
    import d5m_pkg::*;
#(
    parameter int unsigned COLS  = D5M_COLS,
    parameter int unsigned LINES = D5M_LINES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_start,
    input  logic       cmd_stop,
    input  logic       cmd_continuous,
    input  logic [7:0] cmd_frames,
    input  logic       frame_valid,
    input  logic       line_valid,
    input  logic [7:0] data_in,
    input  logic       ready,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       startofpacket,
    output logic       endofpacket,
    output logic       busy,
    output logic [7:0] frames_done,
    output logic       short_frame,
    output logic       overflow,
    output logic       trigger
);

    localparam int unsigned CNT_W = cnt_width(COLS * LINES);

    seq_state_e       state;
    seq_state_e       state_next;
    logic             fv_d;
    logic             cont_q;
    logic [7:0]       frames_q;
    logic [CNT_W-1:0] count;
    logic             first_c;
    logic             last_c;

    logic             fv_rise_c;
    logic             start_c;
    logic             pixel_c;
    logic             eof_c;
    logic             short_c;
    logic             budget_hit_c;
    logic             eof_idle_c;
    logic [7:0]       frames_inc_c;

    logic [7:0]       data_d;
    logic             dv_d;
    logic             sop_d;
    logic             eop_d;
    logic             busy_d;
    logic [7:0]       frames_done_d;
    logic             short_d;
    logic             ovf_d;

    // A rising edge seen in WAIT_SOF may already carry the first pixel.
    assign fv_rise_c    = frame_valid & ~fv_d;
    assign start_c      = cmd_start & ~cmd_stop & (state == IDLE);
    assign pixel_c      = frame_valid & line_valid &
                          ((state == STREAM) | ((state == WAIT_SOF) & fv_rise_c));
    assign eof_c        = pixel_c & last_c;
    assign short_c      = (state == STREAM) & ~frame_valid;
    assign frames_inc_c = (frames_done == 8'hFF) ? 8'hFF : frames_done + 8'd1;
    assign budget_hit_c = cont_q & (frames_q != 8'd0) & (frames_inc_c >= frames_q);
    assign eof_idle_c   = ~cont_q | budget_hit_c;

    d5m_pixel_counter #(
        .COLS  (COLS),
        .LINES (LINES),
        .CNT_W (CNT_W)
    ) u_pixel_counter (
        .clk     (clk),
        .rst     (rst),
        .clear   (state_next != STREAM),
        .advance (pixel_c),
        .count   (count),
        .first_c (first_c),
        .last_c  (last_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (cmd_start) begin
                    state_next = frame_valid ? WAIT_IDLE : WAIT_SOF;
                end
            end
            WAIT_IDLE: begin
                if (!frame_valid) begin
                    state_next = WAIT_SOF;
                end
            end
            WAIT_SOF: begin
                if (eof_c) begin
                    state_next = eof_idle_c ? IDLE : WAIT_SOF;
                end else if (fv_rise_c) begin
                    state_next = STREAM;
                end
            end
            STREAM: begin
                if (eof_c) begin
                    state_next = eof_idle_c ? IDLE : WAIT_SOF;
                end else if (short_c) begin
                    state_next = cont_q ? WAIT_SOF : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (cmd_stop) begin
            state_next = IDLE;
        end
    end

    always_comb begin
        dv_d          = pixel_c & ready & ~cmd_stop;
        sop_d         = dv_d & first_c;
        eop_d         = dv_d & last_c;
        busy_d        = (state_next != IDLE);
        frames_done_d = frames_done;
        short_d       = short_frame;
        ovf_d         = overflow;
`ifdef D5M_SEQ_TEST_PATTERN_EN
        data_d        = 8'(count);
`else
        data_d        = data_in;
`endif
        if (start_c) begin
            frames_done_d = 8'd0;
            short_d       = 1'b0;
            ovf_d         = 1'b0;
        end else if (!cmd_stop) begin
            if (eof_c) begin
                frames_done_d = frames_inc_c;
            end
            if (short_c) begin
                short_d = 1'b1;
            end
            if (pixel_c && !ready) begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_out      <= 8'd0;
            data_valid    <= 1'b0;
            startofpacket <= 1'b0;
            endofpacket   <= 1'b0;
            busy          <= 1'b0;
            trigger       <= 1'b0;
            frames_done   <= 8'd0;
            short_frame   <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            data_out      <= data_d;
            data_valid    <= dv_d;
            startofpacket <= sop_d;
            endofpacket   <= eop_d;
            busy          <= busy_d;
            trigger       <= busy;
            frames_done   <= frames_done_d;
            short_frame   <= short_d;
            overflow      <= ovf_d;
        end
    end

    // Edge history and the mode/budget captured when the sequencer is armed.
    always_ff @(posedge clk) begin
        if (rst) begin
            fv_d     <= 1'b0;
            cont_q   <= 1'b0;
            frames_q <= 8'd0;
        end else begin
            fv_d <= frame_valid;
            if (start_c) begin
                cont_q   <= cmd_continuous;
                frames_q <= cmd_frames;
            end
        end
    end

endmodule

// File: tb/tb_d5m_capture_sequencer.sv
// Randomized self-checking bench for d5m_capture_sequencer (COLS=4, LINES=2).
module tb_d5m_capture_sequencer;

    localparam int COLS  = 4;
    localparam int LINES = 2;
    localparam int NPIX  = COLS * LINES;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_start;
    logic       cmd_stop;
    logic       cmd_continuous;
    logic [7:0] cmd_frames;
    logic       frame_valid;
    logic       line_valid;
    logic [7:0] data_in;
    logic       ready;
    logic [7:0] data_out;
    logic       data_valid;
    logic       startofpacket;
    logic       endofpacket;
    logic       busy;
    logic [7:0] frames_done;
    logic       short_frame;
    logic       overflow;
    logic       trigger;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [9:0] act_q[$];
    logic [9:0] exp_q[$];
    logic [7:0] fdata[NPIX];
    logic       after_dv;
    logic       after_busy;
    logic       after_eop;

    d5m_capture_sequencer #(
        .COLS  (COLS),
        .LINES (LINES)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cmd_start      (cmd_start),
        .cmd_stop       (cmd_stop),
        .cmd_continuous (cmd_continuous),
        .cmd_frames     (cmd_frames),
        .frame_valid    (frame_valid),
        .line_valid     (line_valid),
        .data_in        (data_in),
        .ready          (ready),
        .data_out       (data_out),
        .data_valid     (data_valid),
        .startofpacket  (startofpacket),
        .endofpacket    (endofpacket),
        .busy           (busy),
        .frames_done    (frames_done),
        .short_frame    (short_frame),
        .overflow       (overflow),
        .trigger        (trigger)
    );

    always #5 clk = ~clk;

    // Every delivered beat as {sop, eop, data}.
    always @(negedge clk) begin
        if (data_valid) act_q.push_back({startofpacket, endofpacket, data_out});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] exp_pix(input int i);
`ifdef D5M_SEQ_TEST_PATTERN_EN
        return 8'(i);
`else
        return fdata[i];
`endif
    endfunction

    // Reference: pixel i of a captured frame becomes one beat unless dropped.
    task automatic expect_beats(input int n, input int drop_idx);
        for (int i = 0; i < n; i++) begin
            if (i != drop_idx) exp_q.push_back({1'(i == 0), 1'(i == NPIX - 1), exp_pix(i)});
        end
    endtask

    task automatic arm(input logic cont, input logic [7:0] frames);
        cmd_continuous = cont;
        cmd_frames     = frames;
        cmd_start      = 1'b1;
        tick();
        cmd_start      = 1'b0;
    endtask

    task automatic stop_all();
        cmd_stop = 1'b1;
        tick();
        cmd_stop = 1'b0;
        tick();
        act_q.delete();
        exp_q.delete();
    endtask

    task automatic send_frame(input int npix, input int extra = 0, input int drop_idx = -1,
                              input int start_at = -1, input int stop_at = -1,
                              input int rst_at = -1, input logic [7:0] base = 8'h00,
                              input bit fixed = 1'b0);
        frame_valid = 1'b1;
        line_valid  = 1'b0;
        repeat ($urandom_range(1, 2)) tick();
        for (int i = 0; i < npix + extra; i++) begin
            if (i > 0 && i % COLS == 0) begin
                line_valid = 1'b0;
                repeat ($urandom_range(1, 2)) tick();
            end
            line_valid = 1'b1;
            data_in    = fixed ? base + 8'(i) : 8'($urandom);
            if (i < NPIX) fdata[i] = data_in;
            ready      = (i != drop_idx);
            cmd_start  = (i == start_at);
            cmd_stop   = (i == stop_at);
            rst        = (i == rst_at);
            tick();
            cmd_start = 1'b0;
            cmd_stop  = 1'b0;
            rst       = 1'b0;
            ready     = 1'b1;
            if (i == stop_at || i == rst_at) begin
                after_dv   = data_valid;
                after_busy = busy;
                after_eop  = endofpacket;
            end
        end
        line_valid  = 1'b0;
        frame_valid = 1'b0;
        repeat ($urandom_range(2, 3)) tick();
    endtask

    task automatic test_reset();
        rst            = 1'b1;
        cmd_start      = 1'($urandom);
        frame_valid    = 1'($urandom);
        line_valid     = 1'b1;
        data_in        = 8'($urandom_range(1, 255));
        tick();
        tick();
        n_checks++;
        if (data_out !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_data_out: got %h want 00", data_out);
        end
        n_checks++;
        if (frames_done !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_frames_done: got %0d want 0", frames_done);
        end
        n_checks++;
        if ({data_valid, startofpacket, endofpacket, busy, trigger, short_frame, overflow} !== 7'd0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 0000000",
                     {data_valid, startofpacket, endofpacket, busy, trigger, short_frame, overflow});
        end
        rst = 1'b0; cmd_start = 1'b0; frame_valid = 1'b0; line_valid = 1'b0;
        tick();
    endtask

    task automatic test_single_shot();
        stop_all();
        arm(1'b0, 8'd0);
        n_checks++;
        if ({busy, trigger} !== 2'b10) begin
            n_fail++;
            $display("FAIL single_arm_busy_trigger: got %b want 10", {busy, trigger});
        end
        tick();
        n_checks++;
        if (trigger !== 1'b1) begin
            n_fail++;
            $display("FAIL single_trigger_follow: got %b want 1", trigger);
        end
        send_frame(NPIX, 0, -1, -1, -1, -1, 8'h10, 1'b1);
        expect_beats(NPIX, -1);
        n_checks++;
        if (act_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL single_beat_count: got %0d want %0d", act_q.size(), exp_q.size());
        end else foreach (exp_q[k]) begin
            n_checks++;
            if (act_q[k] !== exp_q[k]) begin
                n_fail++;
                $display("FAIL single_beat%0d: got %h want %h", k, act_q[k], exp_q[k]);
            end
        end
        act_q.delete(); exp_q.delete();
        n_checks++;
        if ({frames_done, busy, trigger} !== {8'd1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL single_done: got fd=%0d busy=%b trig=%b want fd=1 busy=0 trig=0",
                     frames_done, busy, trigger);
        end
        send_frame(NPIX);
        n_checks++;
        if (act_q.size() != 0) begin
            n_fail++;
            $display("FAIL single_idle_ignores: got %0d beats want 0", act_q.size());
        end
    endtask

    task automatic test_start_mid_frame();
        stop_all();
        cmd_continuous = 1'b0;
        cmd_frames     = 8'd0;
        send_frame(NPIX, 0, -1, 2);
        n_checks++;
        if (act_q.size() != 0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midstart_partial: got beats=%0d busy=%b want beats=0 busy=1", act_q.size(), busy);
        end
        send_frame(NPIX);
        expect_beats(NPIX, -1);
        n_checks++;
        if (act_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL midstart_beat_count: got %0d want %0d", act_q.size(), exp_q.size());
        end else foreach (exp_q[k]) begin
            n_checks++;
            if (act_q[k] !== exp_q[k]) begin
                n_fail++;
                $display("FAIL midstart_beat%0d: got %h want %h", k, act_q[k], exp_q[k]);
            end
        end
        act_q.delete(); exp_q.delete();
        n_checks++;
        if ({frames_done, busy} !== {8'd1, 1'b0}) begin
            n_fail++;
            $display("FAIL midstart_done: got fd=%0d busy=%b want fd=1 busy=0", frames_done, busy);
        end
    endtask

    task automatic test_continuous();
        for (int it = 0; it < 3; it++) begin
            int  budget;
            int  drop;
            int  exp_eops;
            int  eops;
            bit  any_drop;
            budget   = (it == 0) ? 3 : int'($urandom_range(1, 4));
            exp_eops = 0;
            eops     = 0;
            any_drop = 1'b0;
            stop_all();
            arm(1'b1, 8'(budget));
            for (int f = 0; f < budget + 2; f++) begin
                drop = -1;
                if (it != 0 && $urandom_range(0, 1) == 1) drop = int'($urandom_range(0, NPIX - 1));
                send_frame(NPIX, 0, drop);
                if (f < budget) begin
                    expect_beats(NPIX, drop);
                    if (drop >= 0) any_drop = 1'b1;
                    if (drop != NPIX - 1) exp_eops++;
                end
            end
            foreach (act_q[k]) eops += int'(act_q[k][8]);
            n_checks++;
            if (eops != exp_eops) begin
                n_fail++;
                $display("FAIL cont_eops: got %0d want %0d", eops, exp_eops);
            end
            n_checks++;
            if (act_q.size() != exp_q.size()) begin
                n_fail++;
                $display("FAIL cont_beat_count: got %0d want %0d", act_q.size(), exp_q.size());
            end else foreach (exp_q[k]) begin
                n_checks++;
                if (act_q[k] !== exp_q[k]) begin
                    n_fail++;
                    $display("FAIL cont_beat%0d: got %h want %h", k, act_q[k], exp_q[k]);
                end
            end
            act_q.delete(); exp_q.delete();
            n_checks++;
            if ({frames_done, busy, overflow} !== {8'(budget), 1'b0, any_drop}) begin
                n_fail++;
                $display("FAIL cont_status: got fd=%0d busy=%b ovf=%b want fd=%0d busy=0 ovf=%b",
                         frames_done, busy, overflow, budget, any_drop);
            end
        end
    endtask

    task automatic test_short_frame();
        stop_all();
        arm(1'b1, 8'd0);
        send_frame(NPIX, 3);
        expect_beats(NPIX, -1);
        send_frame(5);
        expect_beats(5, -1);
        n_checks++;
        if (short_frame !== 1'b1) begin
            n_fail++;
            $display("FAIL short_flag: got %b want 1", short_frame);
        end
        send_frame(NPIX);
        expect_beats(NPIX, -1);
        n_checks++;
        if (act_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL short_beat_count: got %0d want %0d", act_q.size(), exp_q.size());
        end else foreach (exp_q[k]) begin
            n_checks++;
            if (act_q[k] !== exp_q[k]) begin
                n_fail++;
                $display("FAIL short_beat%0d: got %h want %h", k, act_q[k], exp_q[k]);
            end
        end
        act_q.delete(); exp_q.delete();
        n_checks++;
        if ({frames_done, busy, short_frame} !== {8'd2, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL short_status: got fd=%0d busy=%b short=%b want fd=2 busy=1 short=1",
                     frames_done, busy, short_frame);
        end
        stop_all();
        arm(1'b1, 8'd0);
        send_frame(NPIX, 3);
        n_checks++;
        if ({frames_done, short_frame} !== {8'd1, 1'b0}) begin
            n_fail++;
            $display("FAIL extra_pixels: got fd=%0d short=%b want fd=1 short=0", frames_done, short_frame);
        end
    endtask

    task automatic test_overflow();
        for (int it = 0; it < 2; it++) begin
            int drop;
            drop = (it == 0) ? 3 : int'($urandom_range(0, NPIX - 1));
            stop_all();
            arm(1'b0, 8'd0);
            n_checks++;
            if (overflow !== 1'b0) begin
                n_fail++;
                $display("FAIL ovf_clear_on_start: got %b want 0", overflow);
            end
            send_frame(NPIX, 0, drop);
            expect_beats(NPIX, drop);
            n_checks++;
            if (act_q.size() != exp_q.size()) begin
                n_fail++;
                $display("FAIL ovf_beat_count: got %0d want %0d", act_q.size(), exp_q.size());
            end else foreach (exp_q[k]) begin
                n_checks++;
                if (act_q[k] !== exp_q[k]) begin
                    n_fail++;
                    $display("FAIL ovf_beat%0d: got %h want %h", k, act_q[k], exp_q[k]);
                end
            end
            act_q.delete(); exp_q.delete();
            n_checks++;
            if ({overflow, frames_done} !== {1'b1, 8'd1}) begin
                n_fail++;
                $display("FAIL ovf_status: got ovf=%b fd=%0d want ovf=1 fd=1", overflow, frames_done);
            end
        end
    endtask

    task automatic test_stop_rst();
        for (int it = 0; it < 2; it++) begin
            stop_all();
            arm(1'b1, 8'd0);
            if (it == 0) send_frame(NPIX, 0, -1, -1, 4);
            else         send_frame(NPIX, 0, -1, -1, -1, 4);
            expect_beats(4, -1);
            n_checks++;
            if ({after_dv, after_busy, after_eop} !== 3'b000) begin
                n_fail++;
                $display("FAIL abort%0d_next_cycle: got dv=%b busy=%b eop=%b want 000",
                         it, after_dv, after_busy, after_eop);
            end
            n_checks++;
            if (act_q.size() != exp_q.size()) begin
                n_fail++;
                $display("FAIL abort%0d_beat_count: got %0d want %0d", it, act_q.size(), exp_q.size());
            end else foreach (exp_q[k]) begin
                n_checks++;
                if (act_q[k] !== exp_q[k]) begin
                    n_fail++;
                    $display("FAIL abort%0d_beat%0d: got %h want %h", it, k, act_q[k], exp_q[k]);
                end
            end
            act_q.delete(); exp_q.delete();
            n_checks++;
            if ({busy, frames_done} !== {1'b0, 8'd0}) begin
                n_fail++;
                $display("FAIL abort%0d_status: got busy=%b fd=%0d want busy=0 fd=0", it, busy, frames_done);
            end
        end
    endtask

    task automatic test_saturation();
        stop_all();
        arm(1'b1, 8'd0);
        repeat (257) send_frame(NPIX);
        n_checks++;
        if ({frames_done, busy} !== {8'd255, 1'b1}) begin
            n_fail++;
            $display("FAIL sat_frames_done: got fd=%0d busy=%b want fd=255 busy=1", frames_done, busy);
        end
        stop_all();
    endtask

    initial begin
        rst            = 1'b1;
        cmd_start      = 1'b0;
        cmd_stop       = 1'b0;
        cmd_continuous = 1'b0;
        cmd_frames     = 8'd0;
        frame_valid    = 1'b0;
        line_valid     = 1'b0;
        data_in        = 8'd0;
        ready          = 1'b1;
        after_dv       = 1'b0;
        after_busy     = 1'b0;
        after_eop      = 1'b0;
        test_reset();
        test_single_shot();
        test_start_mid_frame();
        test_continuous();
        test_short_frame();
        test_overflow();
        test_stop_rst();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
